// File: rtl/mm_sa_pkg.sv
// Shared register map, window bases and sequencer states for the NxN systolic
// matrix-multiply accelerator.
package mm_sa_pkg;
  localparam logic [7:0]  REG_CONTROL  = 8'h00;
  localparam logic [7:0]  REG_STATUS   = 8'h01;
  localparam logic [7:0]  REG_PARAM    = 8'h02;
  localparam logic [7:0]  A_BASE       = 8'h40;
  localparam logic [7:0]  B_BASE       = 8'h80;
  localparam logic [7:0]  C_BASE       = 8'hC0;
  localparam logic [31:0] UNMAPPED_VAL = 32'h0000_ABCD;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;
endpackage

// File: rtl/mm_systolic_nxn_pe.sv
// Output-stationary MAC cell: forwards a east and b south, accumulates a*b in place.
module systolic_pe
  import mm_sa_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic [ACC_WIDTH-1:0] acc
);
  logic signed [ACC_WIDTH-1:0] a_ext, b_ext;

  assign a_ext = ACC_WIDTH'(signed'(a_in));
  assign b_ext = ACC_WIDTH'(signed'(b_in));

  always_ff @(posedge clk) begin
    if (reset) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= clr ? '0 : acc + ACC_WIDTH'(a_ext * b_ext);
    end
  end
endmodule

// File: rtl/mm_systolic_nxn.sv
// Memory-mapped NxN output-stationary systolic matmul: operand buffers, bus
// decode, skewed wavefront feed and the CLEAR/RUN/DRAIN sequencer.
module mm_systolic_nxn
  import mm_sa_pkg::*;
#(
  parameter int          N            = 4,
  parameter int          WIDTH        = 16,
  parameter int          ACC_WIDTH    = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  wen,
  input  logic [21:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int IDXW = $clog2(N*N);
  localparam int SW   = $clog2(3*N);
  localparam logic [SW-1:0] LAST_STEP = SW'(3*N-3);

  state_t state, state_nx;
  logic [SW-1:0]       step;
  logic                accum, done;
  logic [15:0]         run_cnt;
  logic [WIDTH-1:0]    a_buf [N*N];
  logic [WIDTH-1:0]    b_buf [N*N];
  logic [ACC_WIDTH-1:0] acc_q [N*N];
  logic [WIDTH-1:0]    west  [N];
  logic [WIDTH-1:0]    north [N];
  logic [WIDTH-1:0]    a_grid [N][N+1];
  logic [WIDTH-1:0]    b_grid [N+1][N];

  logic [7:0]      off;
  logic [IDXW-1:0] widx;
  logic            idx_ok, wr, busy, start_wr, clr_acc, done_set, a_wr, b_wr;
  logic [31:0]     rd_nx;

  assign off      = addr[7:0];
  assign widx     = IDXW'(off[5:0]);
  assign idx_ok   = {1'b0, off[5:0]} < 7'(N*N);
  assign wr       = |wen;
  assign busy     = (state != IDLE);
  assign start_wr = wr && (off == REG_CONTROL) && wdata[0] && (state == IDLE);
  assign clr_acc  = (state == CLEAR) && !accum;
  assign done_set = (state == DRAIN);
  assign a_wr     = wr && !busy && idx_ok && (off[7:6] == A_BASE[7:6]);
  assign b_wr     = wr && !busy && idx_ok && (off[7:6] == B_BASE[7:6]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_nx;
      step  <= (state == RUN) ? step + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_wr) state_nx = CLEAR;
      CLEAR:   state_nx = RUN;
      RUN:     if (step == LAST_STEP) state_nx = DRAIN;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Set beats clear: a DONE write-1-clear on the finishing edge loses.
  always_ff @(posedge clk) begin
    if (reset) begin
      accum   <= 1'b0;
      done    <= 1'b0;
      run_cnt <= '0;
    end else begin
      if (wr && off == REG_CONTROL) accum <= wdata[1];
      if (done_set) begin
        done    <= 1'b1;
        run_cnt <= run_cnt + 16'd1;
      end else if (start_wr || (wr && off == REG_STATUS && wdata[1])) begin
        done <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N*N; i++) begin
        a_buf[i] <= '0;
        b_buf[i] <= '0;
      end
    end else begin
      if (a_wr) a_buf[widx] <= wdata[WIDTH-1:0];
      if (b_wr) b_buf[widx] <= wdata[WIDTH-1:0];
    end
  end

  // Row i sees A[i][k-i], column j sees B[k-j][j]; zero outside the diagonal band.
  always_comb begin
    int k;
    k = int'(step);
    for (int i = 0; i < N; i++) begin
      west[i]  = '0;
      north[i] = '0;
      if (state == RUN && k >= i && k - i < N) begin
        west[i]  = a_buf[IDXW'(i*N + k - i)];
        north[i] = b_buf[IDXW'((k - i)*N + i)];
      end
    end
  end

  logic [N-1:0] unused_east, unused_south;
  logic         unused_ok;

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    assign a_grid[gi][0] = west[gi];
    assign b_grid[0][gi] = north[gi];
    assign unused_east[gi]  = ^a_grid[gi][N];
    assign unused_south[gi] = ^b_grid[N][gi];
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      systolic_pe #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .clk  (clk),
        .reset(reset),
        .clr  (clr_acc),
        .a_in (a_grid[gi][gj]),
        .b_in (b_grid[gi][gj]),
        .a_out(a_grid[gi][gj+1]),
        .b_out(b_grid[gi+1][gj]),
        .acc  (acc_q[gi*N + gj])
      );
    end
  end

  assign unused_ok = ^{unused_east, unused_south, addr[21:8], wdata, BASE_ADDRESS};

  always_comb begin
    rd_nx = UNMAPPED_VAL;
    case (off)
      REG_CONTROL: rd_nx = {30'b0, accum, 1'b0};
      REG_STATUS:  rd_nx = {run_cnt, 14'b0, done, busy};
      REG_PARAM:   rd_nx = {8'h0, 8'(ACC_WIDTH), 8'(WIDTH), 8'(N)};
      default: begin
        if (idx_ok) begin
          if (off[7:6] == A_BASE[7:6])      rd_nx = 32'(signed'(a_buf[widx]));
          else if (off[7:6] == B_BASE[7:6]) rd_nx = 32'(signed'(b_buf[widx]));
          else if (off[7:6] == C_BASE[7:6]) rd_nx = 32'(signed'(acc_q[widx]));
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else       rdata <= rd_nx;
  end
endmodule

// File: tb/tb_mm_systolic_nxn.sv
// Randomised bench for mm_systolic_nxn against a plain matrix-product model.
module tb_mm_systolic_nxn;
  import mm_sa_pkg::*;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  wen = '0;
  logic [21:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;

  int tests = 0, fails = 0, exp_runs = 0;
  logic [15:0] ma [N][N];
  logic [15:0] mb [N][N];
  logic [31:0] mc [N][N];
  logic [31:0] dc [N*N];

  mm_systolic_nxn #(.N(N), .WIDTH(16), .ACC_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .wen(wen), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_run(input bit acc_keep);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        logic signed [31:0] s;
        s = acc_keep ? mc[i][j] : 32'sd0;
        for (int m = 0; m < N; m++)
          s = s + 32'(signed'(ma[i][m])) * 32'(signed'(mb[m][j]));
        mc[i][j] = s;
      end
  endfunction

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = {14'b0, a}; wdata = d; wen = 4'hF;
    @(negedge clk);
    wen = 4'h0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = {14'b0, a};
    @(posedge clk);
    #1 d = rdata;
  endtask

  task automatic load_ops();
    logic [31:0] r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        r = $urandom();
        bus_wr(8'(A_BASE + i*N + j), {r[31:16], ma[i][j]});
        r = $urandom();
        bus_wr(8'(B_BASE + i*N + j), {r[31:16], mb[i][j]});
      end
  endtask

  task automatic read_c();
    for (int k = 0; k < N*N; k++) bus_rd(8'(C_BASE + k), dc[k]);
  endtask

  // Returns number of cycles STATUS showed BUSY and the first idle STATUS word.
  task automatic run_and_wait(input logic [31:0] ctrl, output int busy_cyc,
                              output logic [31:0] st);
    bus_wr(REG_CONTROL, ctrl);
    addr = {14'b0, REG_STATUS};
    busy_cyc = 0;
    st = '0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1 st = rdata;
      if (st[0]) busy_cyc++;
      else if (busy_cyc > 0) break;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
    @(negedge clk); reset = 1'b0;
    bus_rd(REG_PARAM, d);
    tests++; if (d !== 32'h0020_1004) begin fails++; $display("FAIL param: got %h expected %h", d, 32'h0020_1004); end
    bus_rd(REG_STATUS, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_status: got %h expected %h", d, 32'h0); end
    bus_rd(REG_CONTROL, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_control: got %h expected %h", d, 32'h0); end
    bus_rd(8'h30, d);
    tests++; if (d !== UNMAPPED_VAL) begin fails++; $display("FAIL unmapped: got %h expected %h", d, UNMAPPED_VAL); end
    bus_rd(8'h50, d);
    tests++; if (d !== UNMAPPED_VAL) begin fails++; $display("FAIL a_window_oob: got %h expected %h", d, UNMAPPED_VAL); end
    bus_rd(8'hCF, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_c33: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_identity();
    int bc; logic [31:0] st;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 16'd1 : 16'd0;
        mb[i][j] = 16'(4*i + j + 1);
      end
    load_ops();
    model_run(1'b0);
    run_and_wait(32'h1, bc, st);
    exp_runs++;
    tests++; if (bc !== 3*N) begin fails++; $display("FAIL identity_busy_len: got %0d expected %0d", bc, 3*N); end
    tests++; if (st !== {16'(exp_runs), 14'b0, 2'b10}) begin fails++; $display("FAIL identity_status: got %h expected %h", st, {16'(exp_runs), 14'b0, 2'b10}); end
    read_c();
    for (int k = 0; k < N*N; k++) begin
      tests++; if (dc[k] !== mc[k/N][k%N]) begin fails++; $display("FAIL identity_c[%0d]: got %h expected %h", k, dc[k], mc[k/N][k%N]); end
    end
  endtask

  task automatic test_random();
    int bc; logic [31:0] st;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ma[i][j] = 16'($urandom());
          mb[i][j] = 16'($urandom());
        end
      load_ops();
      model_run(1'b0);
      run_and_wait(32'h1, bc, st);
      exp_runs++;
      tests++; if (bc !== 3*N) begin fails++; $display("FAIL random_busy_len: got %0d expected %0d", bc, 3*N); end
      read_c();
      for (int k = 0; k < N*N; k++) begin
        tests++; if (dc[k] !== mc[k/N][k%N]) begin fails++; $display("FAIL random_c[%0d] it%0d: got %h expected %h", k, it, dc[k], mc[k/N][k%N]); end
      end
    end
  endtask

  task automatic test_signed_wrap();
    int bc; logic [31:0] st, d;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin ma[i][j] = 16'hFFFF; mb[i][j] = 16'd3; end
    load_ops();
    model_run(1'b0);
    run_and_wait(32'h1, bc, st);
    exp_runs++;
    bus_rd(8'(A_BASE + 2*N + 1), d);
    tests++; if (d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL a21_sext: got %h expected %h", d, 32'hFFFF_FFFF); end
    read_c();
    for (int k = 0; k < N*N; k++) begin
      tests++; if (dc[k] !== mc[k/N][k%N]) begin fails++; $display("FAIL neg_c[%0d]: got %h expected %h", k, dc[k], mc[k/N][k%N]); end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin ma[i][j] = 16'h7FFF; mb[i][j] = 16'h7FFF; end
    load_ops();
    model_run(1'b0);
    run_and_wait(32'h1, bc, st);
    exp_runs++;
    read_c();
    for (int k = 0; k < N*N; k++) begin
      tests++; if (dc[k] !== mc[k/N][k%N]) begin fails++; $display("FAIL maxpos_c[%0d]: got %h expected %h", k, dc[k], mc[k/N][k%N]); end
    end
  endtask

  task automatic test_accum();
    int bc; logic [31:0] st, d;
    logic [31:0] ctrls [3];
    ctrls[0] = 32'h1; ctrls[1] = 32'h3; ctrls[2] = 32'h1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin ma[i][j] = 16'd1; mb[i][j] = 16'd1; end
    load_ops();
    for (int r = 0; r < 3; r++) begin
      model_run(ctrls[r][1]);
      run_and_wait(ctrls[r], bc, st);
      exp_runs++;
      tests++; if (st !== {16'(exp_runs), 14'b0, 2'b10}) begin fails++; $display("FAIL accum_status r%0d: got %h expected %h", r, st, {16'(exp_runs), 14'b0, 2'b10}); end
      read_c();
      for (int k = 0; k < N*N; k++) begin
        tests++; if (dc[k] !== mc[k/N][k%N]) begin fails++; $display("FAIL accum_c[%0d] r%0d: got %h expected %h", k, r, dc[k], mc[k/N][k%N]); end
      end
    end
    bus_wr(REG_STATUS, 32'h2);
    bus_rd(REG_STATUS, d);
    tests++; if (d !== {16'(exp_runs), 16'b0}) begin fails++; $display("FAIL done_w1c: got %h expected %h", d, {16'(exp_runs), 16'b0}); end
  endtask

  task automatic test_busy_writes();
    logic [31:0] st, d;
    bit seen_idle;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 16'($urandom_range(0, 200)) - 16'd100;
        mb[i][j] = 16'($urandom());
      end
    load_ops();
    model_run(1'b0);
    bus_wr(REG_CONTROL, 32'h1);
    bus_wr(A_BASE, 32'd99);
    bus_wr(REG_CONTROL, 32'h1);
    addr = {14'b0, REG_STATUS};
    seen_idle = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1 if (!rdata[0]) begin seen_idle = 1'b1; break; end
    end
    tests++; if (!seen_idle) begin fails++; $display("FAIL busy_timeout: got %0d expected %0d", 0, 1); end
    exp_runs++;
    repeat (5) @(posedge clk);
    bus_rd(REG_STATUS, st);
    tests++; if (st !== {16'(exp_runs), 14'b0, 2'b10}) begin fails++; $display("FAIL busy_ignored_start: got %h expected %h", st, {16'(exp_runs), 14'b0, 2'b10}); end
    bus_rd(A_BASE, d);
    tests++; if (d !== 32'(signed'(ma[0][0]))) begin fails++; $display("FAIL busy_ignored_a00: got %h expected %h", d, 32'(signed'(ma[0][0]))); end
    read_c();
    for (int k = 0; k < N*N; k++) begin
      tests++; if (dc[k] !== mc[k/N][k%N]) begin fails++; $display("FAIL busy_c[%0d]: got %h expected %h", k, dc[k], mc[k/N][k%N]); end
    end
  endtask

  task automatic test_reset_midrun();
    int bc; logic [31:0] st, d;
    bus_wr(REG_CONTROL, 32'h1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_runs = 0;
    bus_rd(REG_STATUS, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL midrun_status: got %h expected %h", d, 32'h0); end
    read_c();
    for (int k = 0; k < N*N; k++) begin
      tests++; if (dc[k] !== 32'h0) begin fails++; $display("FAIL midrun_c[%0d]: got %h expected %h", k, dc[k], 32'h0); end
    end
    for (int k = 0; k < N*N; k++) begin
      bus_rd(8'(A_BASE + k), d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL midrun_a[%0d]: got %h expected %h", k, d, 32'h0); end
      bus_rd(8'(B_BASE + k), d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL midrun_b[%0d]: got %h expected %h", k, d, 32'h0); end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 16'($urandom());
        mb[i][j] = 16'($urandom());
      end
    load_ops();
    model_run(1'b0);
    run_and_wait(32'h1, bc, st);
    exp_runs++;
    tests++; if (bc !== 3*N) begin fails++; $display("FAIL restart_busy_len: got %0d expected %0d", bc, 3*N); end
    tests++; if (st !== {16'(exp_runs), 14'b0, 2'b10}) begin fails++; $display("FAIL restart_status: got %h expected %h", st, {16'(exp_runs), 14'b0, 2'b10}); end
    read_c();
    for (int k = 0; k < N*N; k++) begin
      tests++; if (dc[k] !== mc[k/N][k%N]) begin fails++; $display("FAIL restart_c[%0d]: got %h expected %h", k, dc[k], mc[k/N][k%N]); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_random();
    test_signed_wrap();
    test_accum();
    test_busy_writes();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
